// File: rtl/mem_tile_pkg.sv
// ----------------------------------------------------------------------------
// mem_tile_pkg : shared constants, request classes and helpers for the memory tile
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_tile_pkg;

   localparam int REQ_CGRA = 0;
   localparam int REQ_HOST = 1;

   typedef enum logic [1:0] {
      REQ_IDLE  = 2'd0,
      REQ_READ  = 2'd1,
      REQ_WRITE = 2'd2
   } req_class_e;

   function automatic int num_bytes(input int data_width, input int lane_width);
      return data_width / lane_width;
   endfunction

   // A valid request with no byte enables set is a read.
   function automatic req_class_e classify(input logic valid, input logic any_we);
      if (!valid)
         return REQ_IDLE;
      else if (any_we)
         return REQ_WRITE;
      else
         return REQ_READ;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2 : two-input round-robin arbiter, pointer toggles after each contested grant
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] i_req,
   output logic [1:0] o_grant
);

   logic r_ptr;
   logic w_contend;

   assign w_contend = &i_req;

   always_comb begin
      o_grant = 2'b00;
      if (!reset) begin
         if (w_contend)
            o_grant = r_ptr ? 2'b10 : 2'b01;
         else
            o_grant = i_req;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_ptr <= 1'b0;
      else if (w_contend)
         r_ptr <= ~r_ptr;
   end

endmodule

`default_nettype wire

// File: rtl/sdp_ram_arbiter.sv
// ----------------------------------------------------------------------------
// sdp_ram_arbiter : shares one SDP byte-enable RAM between two requesters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sdp_ram_arbiter
   import mem_tile_pkg::*;
#(
   parameter  int DATA_WIDTH       = 32,
   parameter  int ADDR_WIDTH       = 8,
   parameter  int ADDRESSABLE_SIZE = 8,
   parameter  int CNT_WIDTH        = 16,
   localparam int NUM_BYTES        = num_bytes(DATA_WIDTH, ADDRESSABLE_SIZE)
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  r0_valid,
   input  logic [NUM_BYTES-1:0]  r0_we,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   output logic                  r0_ready,
   output logic                  r0_rsp_valid,
   output logic [DATA_WIDTH-1:0] r0_rsp_data,

   input  logic                  r1_valid,
   input  logic [NUM_BYTES-1:0]  r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r1_ready,
   output logic                  r1_rsp_valid,
   output logic [DATA_WIDTH-1:0] r1_rsp_data,

   output logic [NUM_BYTES-1:0]  ram_wren,
   output logic [ADDR_WIDTH-1:0] ram_wraddress,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_rden,
   output logic [ADDR_WIDTH-1:0] ram_rdaddress,
   input  logic [DATA_WIDTH-1:0] ram_q,

   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   logic [1:0]            w_valid;
   logic [1:0]            w_wr_req;
   logic [1:0]            w_rd_req;
   logic [1:0]            w_wr_gnt;
   logic [1:0]            w_rd_gnt;
   logic [1:0]            w_ready;
   logic                  w_stall;
   logic                  w_fwd;
   logic [DATA_WIDTH-1:0] w_rsp_word;

   logic [1:0]            r_rsp_valid;
   logic                  r_rd_any;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [NUM_BYTES-1:0]  r_wr_we;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic [CNT_WIDTH-1:0]  r_stall_cnt;

   assign w_valid[REQ_CGRA]  = r0_valid;
   assign w_valid[REQ_HOST]  = r1_valid;
   assign w_wr_req[REQ_CGRA] = (classify(r0_valid, |r0_we) == REQ_WRITE);
   assign w_wr_req[REQ_HOST] = (classify(r1_valid, |r1_we) == REQ_WRITE);
   assign w_rd_req[REQ_CGRA] = (classify(r0_valid, |r0_we) == REQ_READ);
   assign w_rd_req[REQ_HOST] = (classify(r1_valid, |r1_we) == REQ_READ);

   rr_arb2 u_wr_arb (
      .clock   (clock),
      .reset   (reset),
      .i_req   (w_wr_req),
      .o_grant (w_wr_gnt)
   );

   rr_arb2 u_rd_arb (
      .clock   (clock),
      .reset   (reset),
      .i_req   (w_rd_req),
      .o_grant (w_rd_gnt)
   );

   assign w_ready  = w_wr_gnt | w_rd_gnt;
   assign r0_ready = w_ready[REQ_CGRA];
   assign r1_ready = w_ready[REQ_HOST];
   assign w_stall  = |(w_valid & ~w_ready);

   always_comb begin
      ram_wren      = '0;
      ram_wraddress = '0;
      ram_data      = '0;
      if (w_wr_gnt[REQ_CGRA]) begin
         ram_wren      = r0_we;
         ram_wraddress = r0_addr;
         ram_data      = r0_wdata;
      end else if (w_wr_gnt[REQ_HOST]) begin
         ram_wren      = r1_we;
         ram_wraddress = r1_addr;
         ram_data      = r1_wdata;
      end
   end

   always_comb begin
      ram_rden      = |w_rd_gnt;
      ram_rdaddress = '0;
      if (w_rd_gnt[REQ_CGRA])
         ram_rdaddress = r0_addr;
      else if (w_rd_gnt[REQ_HOST])
         ram_rdaddress = r1_addr;
   end

   // Snapshot both ports so a same-address collision can be patched up when ram_q returns.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rsp_valid <= '0;
         r_rd_any    <= 1'b0;
         r_rd_addr   <= '0;
         r_wr_addr   <= '0;
         r_wr_we     <= '0;
         r_wr_data   <= '0;
      end else begin
         r_rsp_valid <= w_rd_gnt;
         r_rd_any    <= ram_rden;
         r_rd_addr   <= ram_rdaddress;
         r_wr_addr   <= ram_wraddress;
         r_wr_we     <= ram_wren;
         r_wr_data   <= ram_data;
      end
   end

   assign w_fwd = r_rd_any && (|r_wr_we) && (r_rd_addr == r_wr_addr);

   for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte_fwd
      assign w_rsp_word[b*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE] =
         (w_fwd && r_wr_we[b]) ? r_wr_data[b*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE]
                               : ram_q[b*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE];
   end

   assign r0_rsp_valid = r_rsp_valid[REQ_CGRA];
   assign r1_rsp_valid = r_rsp_valid[REQ_HOST];
   assign r0_rsp_data  = r_rsp_valid[REQ_CGRA] ? w_rsp_word : '0;
   assign r1_rsp_data  = r_rsp_valid[REQ_HOST] ? w_rsp_word : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}}))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sdp_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdp_ram_arbiter : directed bench with a response scoreboard and a behavioural SDP RAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sdp_ram_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        r0_valid, r1_valid;
   logic [3:0]  r0_we, r1_we;
   logic [7:0]  r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;
   logic        r0_ready, r1_ready;
   logic        r0_rsp_valid, r1_rsp_valid;
   logic [31:0] r0_rsp_data, r1_rsp_data;
   logic [3:0]  ram_wren;
   logic [7:0]  ram_wraddress, ram_rdaddress;
   logic [31:0] ram_data, ram_q;
   logic        ram_rden;
   logic [15:0] stall_cnt;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp0[$];
   exp_t        exp1[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          mon_idle_chk = 1'b1;
   logic [31:0] mem [256];

   sdp_ram_arbiter dut (
      .clock         (clock),
      .reset         (reset),
      .r0_valid      (r0_valid),
      .r0_we         (r0_we),
      .r0_addr       (r0_addr),
      .r0_wdata      (r0_wdata),
      .r0_ready      (r0_ready),
      .r0_rsp_valid  (r0_rsp_valid),
      .r0_rsp_data   (r0_rsp_data),
      .r1_valid      (r1_valid),
      .r1_we         (r1_we),
      .r1_addr       (r1_addr),
      .r1_wdata      (r1_wdata),
      .r1_ready      (r1_ready),
      .r1_rsp_valid  (r1_rsp_valid),
      .r1_rsp_data   (r1_rsp_data),
      .ram_wren      (ram_wren),
      .ram_wraddress (ram_wraddress),
      .ram_data      (ram_data),
      .ram_rden      (ram_rden),
      .ram_rdaddress (ram_rdaddress),
      .ram_q         (ram_q),
      .stall_cnt     (stall_cnt)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural RAM: a same-cycle read returns the old word.
   always @(posedge clock) begin
      for (int b = 0; b < 4; b++)
         if (ram_wren[b]) mem[ram_wraddress][b*8 +: 8] <= ram_data[b*8 +: 8];
      if (ram_rden) ram_q <= mem[ram_rdaddress];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (r0_rsp_valid) begin
         if (exp0.size() == 0) chk("r0_rsp_unexpected", 32'd1, 32'd0);
         else begin
            e = exp0.pop_front();
            chk("r0_rsp_data", r0_rsp_data, e.data);
            chk("r0_rsp_latency", cyc, e.cyc + 1);
         end
      end else if (mon_idle_chk) chk("r0_rsp_data_idle", r0_rsp_data, 32'd0);
      if (r1_rsp_valid) begin
         if (exp1.size() == 0) chk("r1_rsp_unexpected", 32'd1, 32'd0);
         else begin
            e = exp1.pop_front();
            chk("r1_rsp_data", r1_rsp_data, e.data);
            chk("r1_rsp_latency", cyc, e.cyc + 1);
         end
      end else if (mon_idle_chk) chk("r1_rsp_data_idle", r1_rsp_data, 32'd0);
   end

   task automatic expect_rsp(input int n, input logic [31:0] d);
      exp_t e;
      e.data = d;
      e.cyc  = cyc;
      if (n == 0) exp0.push_back(e);
      else        exp1.push_back(e);
   endtask

   task automatic set_in(input logic v0, input logic [3:0] we0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [3:0] we1, input logic [7:0] a1, input logic [31:0] d1);
      r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
      r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
   endtask

   // Drive one cycle of requests just after the rising edge, then sit at the falling edge.
   task automatic issue(input logic v0, input logic [3:0] we0, input logic [7:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [3:0] we1, input logic [7:0] a1, input logic [31:0] d1);
      @(posedge clock);
      #1;
      set_in(v0, we0, a0, d0, v1, we1, a1, d1);
      @(negedge clock);
   endtask

   task automatic idle_cycle();
      issue(0, 4'h0, 8'h00, 32'h0, 0, 4'h0, 8'h00, 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      set_in(1, 4'h0, 8'h10, 32'h0, 1, 4'hF, 8'h10, 32'h12345678);
      @(negedge clock);
      chk("reset_r0_ready", {31'd0, r0_ready}, 32'd0);
      chk("reset_r1_ready", {31'd0, r1_ready}, 32'd0);
      chk("reset_ram_wren", {28'd0, ram_wren}, 32'd0);
      chk("reset_ram_rden", {31'd0, ram_rden}, 32'd0);
      chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      set_in(0, 4'h0, 8'h00, 32'h0, 0, 4'h0, 8'h00, 32'h0);

      // Write then read back through requester 0
      issue(1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 4'h0, 8'h00, 32'h0);
      chk("t1_wr_ready", {31'd0, r0_ready}, 32'd1);
      chk("t1_ram_wren", {28'd0, ram_wren}, 32'h0000000F);
      chk("t1_ram_wraddr", {24'd0, ram_wraddress}, 32'h10);
      chk("t1_ram_data", ram_data, 32'hDEADBEEF);
      issue(1, 4'h0, 8'h10, 32'h0, 0, 4'h0, 8'h00, 32'h0);
      chk("t1_rd_ready", {31'd0, r0_ready}, 32'd1);
      chk("t1_ram_rden", {31'd0, ram_rden}, 32'd1);
      chk("t1_ram_rdaddr", {24'd0, ram_rdaddress}, 32'h10);
      expect_rsp(0, 32'hDEADBEEF);
      issue(1, 4'hF, 8'h31, 32'h55667788, 0, 4'h0, 8'h00, 32'h0);
      issue(0, 4'h0, 8'h00, 32'h0, 1, 4'hF, 8'h20, 32'hAABBCCDD);
      chk("preload_r1_ready", {31'd0, r1_ready}, 32'd1);
      idle_cycle();
      chk("t1_stall_cnt", {16'd0, stall_cnt}, 32'd0);

      // Contested writes alternate starting with requester 0
      for (int i = 0; i < 4; i++) begin
         issue(1, 4'hF, 8'h01, 32'h01010101, 1, 4'hF, 8'h02, 32'h02020202);
         chk($sformatf("t2_r0_ready_%0d", i), {31'd0, r0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("t2_r1_ready_%0d", i), {31'd0, r1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      idle_cycle();
      chk("t2_stall_cnt", {16'd0, stall_cnt}, 32'd4);

      // Same-address read/write collision with partial byte enables
      issue(1, 4'h0, 8'h20, 32'h0, 1, 4'b0101, 8'h20, 32'h11223344);
      chk("t3_r0_ready", {31'd0, r0_ready}, 32'd1);
      chk("t3_r1_ready", {31'd0, r1_ready}, 32'd1);
      expect_rsp(0, 32'hAA22CC44);
      idle_cycle();
      issue(0, 4'h0, 8'h00, 32'h0, 1, 4'h0, 8'h20, 32'h0);
      expect_rsp(1, 32'hAA22CC44);

      // Write and read to different addresses proceed together without stalls
      issue(1, 4'hF, 8'h30, 32'h99999999, 1, 4'h0, 8'h31, 32'h0);
      chk("t4_r0_ready", {31'd0, r0_ready}, 32'd1);
      chk("t4_r1_ready", {31'd0, r1_ready}, 32'd1);
      expect_rsp(1, 32'h55667788);
      idle_cycle();
      chk("t4_stall_cnt", {16'd0, stall_cnt}, 32'd4);

      // Contested reads give back-to-back responses
      issue(1, 4'h0, 8'h10, 32'h0, 1, 4'h0, 8'h31, 32'h0);
      chk("t5_r0_ready", {31'd0, r0_ready}, 32'd1);
      chk("t5_r1_ready", {31'd0, r1_ready}, 32'd0);
      expect_rsp(0, 32'hDEADBEEF);
      issue(0, 4'h0, 8'h00, 32'h0, 1, 4'h0, 8'h31, 32'h0);
      chk("t5_r1_ready_2", {31'd0, r1_ready}, 32'd1);
      expect_rsp(1, 32'h55667788);
      idle_cycle();
      chk("t5_stall_cnt", {16'd0, stall_cnt}, 32'd5);

      // Async reset drops an in-flight read and returns both pointers to requester 0
      issue(1, 4'hF, 8'h01, 32'h01010101, 1, 4'hF, 8'h02, 32'h02020202);
      chk("t6_pre_r0_ready", {31'd0, r0_ready}, 32'd1);
      issue(1, 4'h0, 8'h10, 32'h0, 1, 4'hF, 8'h02, 32'h02020202);
      chk("t6_rd_ready", {31'd0, r0_ready}, 32'd1);
      chk("t6_wr_ready", {31'd0, r1_ready}, 32'd1);
      @(posedge clock);
      #1;
      set_in(0, 4'h0, 8'h00, 32'h0, 0, 4'h0, 8'h00, 32'h0);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      @(negedge clock);
      chk("t6_rsp_dropped", {31'd0, r0_rsp_valid}, 32'd0);
      chk("t6_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      issue(1, 4'hF, 8'h01, 32'h01010101, 1, 4'hF, 8'h02, 32'h02020202);
      chk("t6_wptr_r0", {31'd0, r0_ready}, 32'd1);
      chk("t6_wptr_r1", {31'd0, r1_ready}, 32'd0);
      issue(1, 4'h0, 8'h10, 32'h0, 1, 4'h0, 8'h31, 32'h0);
      chk("t6_rptr_r0", {31'd0, r0_ready}, 32'd1);
      chk("t6_rptr_r1", {31'd0, r1_ready}, 32'd0);
      expect_rsp(0, 32'hDEADBEEF);
      issue(0, 4'h0, 8'h00, 32'h0, 1, 4'h0, 8'h31, 32'h0);
      expect_rsp(1, 32'h55667788);
      idle_cycle();

      // Stall counter saturates instead of wrapping
      mon_idle_chk = 1'b0;
      @(posedge clock);
      #1;
      set_in(1, 4'hF, 8'h01, 32'h01010101, 1, 4'hF, 8'h02, 32'h02020202);
      repeat (65541) @(posedge clock);
      #1;
      set_in(0, 4'h0, 8'h00, 32'h0, 0, 4'h0, 8'h00, 32'h0);
      @(negedge clock);
      chk("t7_stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
      mon_idle_chk = 1'b1;
      issue(1, 4'hF, 8'h01, 32'h01010101, 1, 4'hF, 8'h02, 32'h02020202);
      idle_cycle();
      chk("t7_stall_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

      idle_cycle();
      chk("exp0_drained", exp0.size(), 32'd0);
      chk("exp1_drained", exp1.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
